rx232: RTL and testbench

Asynchronous serial receiver, the receive-side counterpart of the team's 8N1 UART transmitter. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from `rxsd`, using a 16× oversampling clock input `rxck` that is edge-detected in the `clk` domain. Received bytes go to the host through a ready/acknowledge handshake, with framing-error and overrun reporting. It sits next to the transmitter in the UART top level and shares its `clk`/`rst`.

---
 rtl/rx232_pkg.sv | 19 +
 rtl/rx232_sync.sv | 30 +++
 rtl/rx232.sv | 138 +++++++++++++
 tb/tb_rx232.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx232_pkg.sv
// Shared types and constants for the rx232 8N1 serial receiver.
package rx232_pkg;

  localparam int DATA_BITS = 8;
  localparam int DEF_OVS   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx232_sync.sv
// Input conditioning for rx232: rxsd synchronizer and rxck rising-edge detector.
module rx232_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxck,
  input  logic rxsd,
  output logic sd,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sd_q;
  logic [1:0]             ck_q;

  // The serial line resets to its idle level so no false start is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_q <= '1;
      ck_q <= '0;
    end else begin
      sd_q <= {sd_q[SYNC_STAGES-2:0], rxsd};
      ck_q <= {ck_q[0], rxck};
    end
  end

  assign sd   = sd_q[SYNC_STAGES-1];
  assign tick = ck_q[0] & ~ck_q[1];

endmodule

// File: rtl/rx232.sv
// 8N1 serial receiver with 16x-style oversampling, ready/ack host handshake,
// framing-error pulse and sticky overrun. Define RX232_MAJORITY_EN for 2-of-3 voting.
module rx232
  import rx232_pkg::*;
#(
  parameter int OVS         = DEF_OVS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxck,
  input  logic                 rxsd,
  input  logic                 rxack,
  output logic [DATA_BITS-1:0] rxpd,
  output logic                 rxrdy,
  output logic                 rxferr,
  output logic                 rxovr,
  output logic                 rxbusy,
  output logic [2:0]           rxstate
);

  localparam int SW  = $clog2(OVS);
  localparam int MID = OVS / 2;
`ifdef RX232_MAJORITY_EN
  localparam int DEC = MID + 1;
`else
  localparam int DEC = MID;
`endif

  logic                 sd;
  logic                 tick;
  logic                 bitv;
  logic                 dec;
  rx_state_t            state;
  logic [SW-1:0]        scnt;
  logic [2:0]           bcnt;
  logic [DATA_BITS-1:0] sr;

  rx232_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .rxck (rxck),
    .rxsd (rxsd),
    .sd   (sd),
    .tick (tick)
  );

`ifdef RX232_MAJORITY_EN
  logic samp_a;
  logic samp_b;

  // Early samples are held so the vote can complete on the decision tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (scnt == SW'(MID - 1)) samp_a <= sd;
      if (scnt == SW'(MID))     samp_b <= sd;
    end
  end

  assign bitv = maj3(samp_a, samp_b, sd);
`else
  assign bitv = sd;
`endif

  assign dec     = (scnt == SW'(DEC));
  assign rxbusy  = (state != IDLE);
  assign rxstate = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      scnt   <= '0;
      bcnt   <= '0;
      sr     <= '0;
      rxpd   <= '0;
      rxrdy  <= 1'b0;
      rxferr <= 1'b0;
      rxovr  <= 1'b0;
    end else begin
      rxferr <= 1'b0;
      if (rxack) begin
        rxrdy <= 1'b0;
        rxovr <= 1'b0;
      end
      if (tick) begin
        if (state != IDLE)
          scnt <= (scnt == SW'(OVS - 1)) ? '0 : scnt + 1'b1;
        case (state)
          IDLE: begin
            if (!sd) begin
              state <= START;
              scnt  <= '0;
            end
          end
          START: begin
            if (dec) begin
              if (bitv) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                bcnt  <= '0;
              end
            end
          end
          DATA: begin
            if (dec) begin
              sr <= {bitv, sr[DATA_BITS-1:1]};
              if (bcnt == 3'd7) state <= STOP;
              else              bcnt  <= bcnt + 3'd1;
            end
          end
          STOP: begin
            if (dec) begin
              if (bitv) begin
                // A new byte beats a same-cycle ack, so rxrdy stays set.
                rxpd  <= sr;
                rxrdy <= 1'b1;
                if (rxrdy && !rxack) rxovr <= 1'b1;
                state <= IDLE;
              end else begin
                rxferr <= 1'b1;
                state  <= WAIT_HI;
              end
            end
          end
          WAIT_HI: begin
            if (sd) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx232.sv
// Self-checking bench for rx232: drives 8N1 frames on rxsd and checks received bytes,
// handshake, framing error, overrun, glitch rejection and mid-frame reset.
module tb_rx232;

  localparam int OVS     = 16;
  localparam int CK_HALF = 20;
  localparam int BIT     = OVS * 2 * CK_HALF;
  localparam int BIT_CLK = BIT / 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxck = 1'b0;
  logic       rxsd;
  logic       rxack;
  logic [7:0] rxpd;
  logic       rxrdy;
  logic       rxferr;
  logic       rxovr;
  logic       rxbusy;
  logic [2:0] rxstate;

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;
  int rdy_rise = 0;
  logic rdy_prev = 1'b0;
  logic [7:0] exp_q[$];

  rx232 #(.OVS(OVS), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .rxck    (rxck),
    .rxsd    (rxsd),
    .rxack   (rxack),
    .rxpd    (rxpd),
    .rxrdy   (rxrdy),
    .rxferr  (rxferr),
    .rxovr   (rxovr),
    .rxbusy  (rxbusy),
    .rxstate (rxstate)
  );

  // clock / reset block
  initial forever #5 clk = ~clk;
  initial forever #(CK_HALF) rxck = ~rxck;

  always @(negedge clk) begin
    if (rxferr) ferr_cnt++;
    if (rxrdy && !rdy_prev) rdy_rise++;
    rdy_prev = rxrdy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_frame(input logic [7:0] d, input logic stop);
    rxsd = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rxsd = d[i];
      #(BIT);
    end
    rxsd = stop;
    #(BIT);
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    rxack = 1'b1;
    @(negedge clk);
    rxack = 1'b0;
  endtask

  task automatic wait_rdy(input int max_clk, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_clk; i++) begin
      @(negedge clk);
      if (rxrdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; rxsd = 1'b1; rxack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rxpd, rxrdy, rxferr, rxovr, rxbusy, rxstate} !== 15'h0) begin
      failures++;
      $display("FAIL reset_hold: got pd=%h rdy=%b ferr=%b ovr=%b busy=%b st=%0d, want all 0",
               rxpd, rxrdy, rxferr, rxovr, rxbusy, rxstate);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({rxpd, rxrdy, rxferr, rxovr, rxbusy, rxstate} !== 15'h0) begin
      failures++;
      $display("FAIL reset_release: got pd=%h rdy=%b busy=%b st=%0d, want all 0",
               rxpd, rxrdy, rxbusy, rxstate);
    end
  endtask

  task automatic test_single;
    bit ok;
    int f0 = ferr_cnt;
    send_frame(8'h55, 1'b1);
    wait_rdy(BIT_CLK, ok);
    checks++;
    if (!ok || rxpd !== 8'h55) begin
      failures++;
      $display("FAIL single_55: got rdy=%b pd=%h, want rdy=1 pd=55", rxrdy, rxpd);
    end
    checks++;
    if (ferr_cnt !== f0 || rxovr !== 1'b0) begin
      failures++;
      $display("FAIL single_flags: got ferr_pulses=%0d ovr=%b, want 0 and 0", ferr_cnt - f0, rxovr);
    end
    pulse_ack;
    checks++;
    if (rxrdy !== 1'b0) begin
      failures++;
      $display("FAIL single_ack: got rdy=%b, want 0", rxrdy);
    end
  endtask

  task automatic test_back_to_back;
    int r0 = rdy_rise;
    exp_q.delete();
    fork
      begin
        exp_q.push_back(8'hA5); send_frame(8'hA5, 1'b1);
        exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1);
      end
      begin
        for (int j = 0; j < 2; j++) begin
          bit ok;
          logic [7:0] e;
          wait_rdy(BIT_CLK * 12, ok);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          checks++;
          if (!ok || rxpd !== e || rxovr !== 1'b0) begin
            failures++;
            $display("FAIL b2b_byte%0d: got rdy=%b pd=%h ovr=%b, want rdy=1 pd=%h ovr=0",
                     j, rxrdy, rxpd, rxovr, e);
          end
          pulse_ack;
        end
      end
    join
    checks++;
    if (rdy_rise - r0 !== 2) begin
      failures++;
      $display("FAIL b2b_rises: got %0d rxrdy rises, want 2", rdy_rise - r0);
    end
  endtask

  task automatic test_glitch;
    int f0 = ferr_cnt;
    int r0 = rdy_rise;
    rxsd = 1'b0;
    #(4 * 2 * CK_HALF);
    rxsd = 1'b1;
    @(negedge clk);
    checks++;
    if (rxbusy !== 1'b1) begin
      failures++;
      $display("FAIL glitch_start: got busy=%b, want 1", rxbusy);
    end
    #(BIT);
    checks++;
    if (rxbusy !== 1'b0 || rdy_rise !== r0 || ferr_cnt !== f0 || rxrdy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_reject: got busy=%b rdy=%b rises=%0d ferrs=%0d, want 0 0 0 0",
               rxbusy, rxrdy, rdy_rise - r0, ferr_cnt - f0);
    end
  endtask

  task automatic test_framing;
    bit ok;
    int f0 = ferr_cnt;
    send_frame(8'h00, 1'b0);
    rxsd = 1'b0;
    #(20 * BIT);
    checks++;
    if (ferr_cnt - f0 !== 1 || rxrdy !== 1'b0 || rxstate !== 3'd4 || rxbusy !== 1'b1) begin
      failures++;
      $display("FAIL framing: got ferr_pulses=%0d rdy=%b st=%0d busy=%b, want 1 0 4 1",
               ferr_cnt - f0, rxrdy, rxstate, rxbusy);
    end
    rxsd = 1'b1;
    #(BIT);
    checks++;
    if (rxbusy !== 1'b0) begin
      failures++;
      $display("FAIL framing_recover: got busy=%b, want 0", rxbusy);
    end
    send_frame(8'h81, 1'b1);
    wait_rdy(BIT_CLK, ok);
    checks++;
    if (!ok || rxpd !== 8'h81 || ferr_cnt - f0 !== 1) begin
      failures++;
      $display("FAIL framing_next: got rdy=%b pd=%h ferrs=%0d, want 1 81 1", rxrdy, rxpd, ferr_cnt - f0);
    end
    pulse_ack;
  endtask

  task automatic test_overrun;
    send_frame(8'h11, 1'b1);
    #(BIT / 4);
    checks++;
    if (rxrdy !== 1'b1 || rxovr !== 1'b0 || rxpd !== 8'h11) begin
      failures++;
      $display("FAIL ovr_first: got rdy=%b ovr=%b pd=%h, want 1 0 11", rxrdy, rxovr, rxpd);
    end
    send_frame(8'h22, 1'b1);
    #(BIT / 4);
    checks++;
    if (rxrdy !== 1'b1 || rxovr !== 1'b1 || rxpd !== 8'h22) begin
      failures++;
      $display("FAIL ovr_second: got rdy=%b ovr=%b pd=%h, want 1 1 22", rxrdy, rxovr, rxpd);
    end
    pulse_ack;
    checks++;
    if (rxrdy !== 1'b0 || rxovr !== 1'b0) begin
      failures++;
      $display("FAIL ovr_ack: got rdy=%b ovr=%b, want 0 0", rxrdy, rxovr);
    end
  endtask

  task automatic test_mid_reset;
    bit ok;
    int f0 = ferr_cnt;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        #(5 * BIT + BIT / 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rxpd, rxrdy, rxferr, rxovr, rxbusy, rxstate} !== 15'h0) begin
          failures++;
          $display("FAIL midrst_outputs: got pd=%h rdy=%b ovr=%b busy=%b st=%0d, want all 0",
                   rxpd, rxrdy, rxovr, rxbusy, rxstate);
        end
      end
    join
    checks++;
    if (rxrdy !== 1'b0 || rxbusy !== 1'b0 || ferr_cnt !== f0) begin
      failures++;
      $display("FAIL midrst_tail: got rdy=%b busy=%b ferrs=%0d, want 0 0 0", rxrdy, rxbusy, ferr_cnt - f0);
    end
    send_frame(8'h0F, 1'b1);
    wait_rdy(BIT_CLK, ok);
    checks++;
    if (!ok || rxpd !== 8'h0F) begin
      failures++;
      $display("FAIL midrst_next: got rdy=%b pd=%h, want 1 0f", rxrdy, rxpd);
    end
    pulse_ack;
  endtask

  task automatic test_random;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [7:0] b;
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_frame(b, 1'b1);
          if ($urandom_range(0, 1) == 1) #(BIT * $urandom_range(1, 3));
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          bit ok;
          logic [7:0] e;
          wait_rdy(BIT_CLK * 16, ok);
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          checks++;
          if (!ok || rxpd !== e || rxovr !== 1'b0) begin
            failures++;
            $display("FAIL random_byte%0d: got rdy=%b pd=%h ovr=%b, want rdy=1 pd=%h ovr=0",
                     j, rxrdy, rxpd, rxovr, e);
          end
          pulse_ack;
        end
      end
    join
  endtask

`ifdef RX232_MAJORITY_EN
  task automatic send_glitchy(input logic [7:0] d);
    rxsd = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rxsd = d[i];
      #(BIT / 2 - CK_HALF);
      rxsd = ~d[i];
      #(2 * CK_HALF);
      rxsd = d[i];
      #(BIT / 2 - CK_HALF);
    end
    rxsd = 1'b1;
    #(BIT);
  endtask

  task automatic test_majority;
    bit ok;
    send_glitchy(8'h96);
    wait_rdy(BIT_CLK, ok);
    checks++;
    if (!ok || rxpd !== 8'h96) begin
      failures++;
      $display("FAIL majority_96: got rdy=%b pd=%h, want 1 96", rxrdy, rxpd);
    end
    pulse_ack;
  endtask
`endif

  initial begin
    test_reset();
    #(2 * BIT);
    test_single();
    test_back_to_back();
    #(BIT);
    test_glitch();
    test_framing();
    test_overrun();
    test_mid_reset();
    test_random();
`ifdef RX232_MAJORITY_EN
    test_majority();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
